uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Serial front end of the GPU. Receives 8N1 UART bytes on `rx`, frames them as sync byte + 60 payload bytes + checksum, and emits one `update_reg` write strobe per payload byte with its index. This drives the top-level scene register bank (vertices, normal, light, VP matrix). A single `pc_ready` pulse after a frame whose checksum is valid tells the vertex shader to recompute.

## Interface
- `CLKS_PER_BIT`, 434: clocks per UART bit (50 MHz / 115200); minimum 4.
- `FRAME_BYTES`, 60: payload bytes per frame; maximum 64.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 16*CLKS_PER_BIT: maximum idle gap between bytes inside a frame.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `rx`, in, 1: UART line, idle high, asynchronous to `clk`.
- `read_data`, out, 8: payload byte; valid while `update_reg` is high, held until the next payload byte.
- `idx`, out, 6: payload index 0..FRAME_BYTES-1 of `read_data`.
- `update_reg`, out, 1: one-cycle write strobe.
- `pc_ready`, out, 1: one-cycle pulse when a frame completes with a good checksum.
- `frame_err`, out, 1: one-cycle pulse on checksum mismatch, stop-bit error inside a frame, or inter-byte timeout.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1.
- RX core states:
  - IDLE: wait for a falling edge.
  - START: count CLKS_PER_BIT/2. If the line is still low, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample one bit. If 1, raise `byte_valid` for 1 cycle; if 0, raise `byte_err` for 1 cycle. Return to IDLE.
- Parser states:
  - HUNT: bytes other than SYNC_BYTE are ignored silently. SYNC_BYTE clears the byte counter and the checksum, then goes to PAYLOAD.
  - PAYLOAD: each byte is driven out with `idx` = counter and pulses `update_reg`. The byte is added to the checksum (8-bit, wraps mod 256). The counter increments; after byte FRAME_BYTES-1, go to CHECK. SYNC_BYTE values inside the payload are ordinary data.
  - CHECK: the next byte is compared with the checksum. On a match, pulse `pc_ready`; otherwise pulse `frame_err`. Go to HUNT in both cases.
- `byte_err` in HUNT: ignored. In PAYLOAD or CHECK: pulse `frame_err`, go to HUNT.
- Timeout counter: cleared on every `byte_valid` and counts while in PAYLOAD or CHECK. Reaching TIMEOUT_CLKS pulses `frame_err` and goes to HUNT.
- Writes already issued by an aborted frame are not rescinded. Consumers act only on `pc_ready`.
- Reset, including mid-frame: parser to HUNT, RX core to IDLE, all counters 0.

## Timing
- Reset values: `read_data`=0, `idx`=0, `update_reg`=0, `pc_ready`=0, `frame_err`=0.
- Outputs are all registered.
- `update_reg` rises 1 clk after the internal `byte_valid`. `byte_valid` occurs at mid-stop-bit, about 9.5 bit times after the start edge plus 2 synchronizer clocks.
- `pc_ready` and `frame_err` rise 1 clk after the checksum byte's `byte_valid`.
- The three strobes are mutually exclusive in any cycle.
- Minimum spacing between `update_reg` pulses is 10*CLKS_PER_BIT clocks.
- Back-to-back bytes: a new start edge is accepted the cycle after STOP sampling.
- A start edge arriving exactly on the timeout cycle: the timeout wins, and that byte is treated as a HUNT byte.

## Structure
- Shared package `gpu_pkg`: FRAME_BYTES, SYNC_BYTE, IDX_W=6, and the parser state enum.
- Sub-module `uart_rx_core`:
  - Inputs: `clk`, `rst_n`, `rx_sync`.
  - Outputs: `data[7:0]`, `byte_valid`, `byte_err`.
  - Parameter: CLKS_PER_BIT.
- `uart_frame_loader` holds the synchronizer, parser FSM, byte counter, checksum and timeout counter.

## Test plan
All scenarios use CLKS_PER_BIT=8.
1. Send A5, bytes 00..3B, EA. Required: 60 `update_reg` pulses with `idx`=`read_data`=0..59, then one `pc_ready`, no `frame_err`.
2. Same frame with checksum EB. Required: 60 writes, `frame_err` pulse, no `pc_ready`.
3. Send 00, 3C, FF, then A5 plus a valid frame. Required: the first three bytes produce no strobes; the frame completes normally.
4. Payload byte 10 = A5 with correct checksum. Required: `idx`=10 carries A5, no re-sync, `pc_ready` asserted.
5. Send A5 plus 20 bytes, then idle beyond TIMEOUT_CLKS. Required: 20 writes, one `frame_err`; the next full frame yields `pc_ready`.
6. Low glitch of 3 clks on `rx`, then stop bit forced 0 in payload byte 5, then `rst_n` low mid-frame. Required: glitch ignored; `frame_err` on byte 5; after reset all outputs 0 and parser in HUNT.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and state types for the GPU serial front end.
package gpu_pkg;

   localparam int         FRAME_BYTES = 60;
   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         IDX_W       = 6;

   typedef enum logic [1:0] {
      P_HUNT,
      P_PAYLOAD,
      P_CHECK
   } parser_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver working on an already-synchronized line.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a 1->0 transition
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sample 8 data bits one bit-time apart, LSB first
// RX_STOP  | sample stop bit, flag good byte or framing error
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_sync,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       byte_err
);
   import gpu_pkg::*;

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_rx_prev;
   logic             r_byte_valid;
   logic             r_byte_err;

   assign data       = r_shift;
   assign byte_valid = r_byte_valid;
   assign byte_err   = r_byte_err;

   // Bit-timing FSM; the bit timer is a down-counter, every decision is taken at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RX_IDLE;
         r_cnt        <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rx_prev    <= 1'b1;
         r_byte_valid <= 1'b0;
         r_byte_err   <= 1'b0;
      end else begin
         r_rx_prev    <= rx_sync;
         r_byte_valid <= 1'b0;
         r_byte_err   <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (r_rx_prev && !rx_sync) begin
                  r_state <= RX_START;
                  r_cnt   <= HALF_LOAD;
               end
            end
            RX_START: begin
               if (r_cnt == '0) begin
                  if (!rx_sync) begin
                     r_state   <= RX_DATA;
                     r_cnt     <= FULL_LOAD;
                     r_bit_cnt <= 3'd7;
                  end else begin
                     r_state <= RX_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == '0) begin
                  r_shift <= {rx_sync, r_shift[7:1]};
                  r_cnt   <= FULL_LOAD;
                  if (r_bit_cnt == '0) begin
                     r_state <= RX_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == '0) begin
                  r_byte_valid <= rx_sync;
                  r_byte_err   <= !rx_sync;
                  r_state      <= RX_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader: sync byte + payload + 8-bit additive checksum,
// one register write strobe per payload byte, pc_ready on a good frame.
//
// state     | meaning
// ----------|------------------------------------------------------------
// P_HUNT    | discard bytes until the sync byte arrives
// P_PAYLOAD | forward payload bytes as indexed writes, accumulate checksum
// P_CHECK   | next byte is the checksum; pc_ready or frame_err, then hunt
module uart_frame_loader #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         FRAME_BYTES  = gpu_pkg::FRAME_BYTES,
   parameter logic [7:0] SYNC_BYTE    = gpu_pkg::SYNC_BYTE,
   parameter int         TIMEOUT_CLKS = 16 * CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx,
   output logic [7:0]                read_data,
   output logic [gpu_pkg::IDX_W-1:0] idx,
   output logic                      update_reg,
   output logic                      pc_ready,
   output logic                      frame_err
);
   import gpu_pkg::*;

   localparam int               TO_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CLKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   logic             r_rx_meta;
   logic             r_rx_sync;
   logic [7:0]       w_data;
   logic             w_byte_valid;
   logic             w_byte_err;
   logic             w_timeout;

   parser_state_t    r_state;
   logic [IDX_W-1:0] r_cnt;
   logic [7:0]       r_sum;
   logic [TO_W-1:0]  r_to_cnt;
   logic [7:0]       r_read_data;
   logic [IDX_W-1:0] r_idx;
   logic             r_update_reg;
   logic             r_pc_ready;
   logic             r_frame_err;

   assign read_data  = r_read_data;
   assign idx        = r_idx;
   assign update_reg = r_update_reg;
   assign pc_ready   = r_pc_ready;
   assign frame_err  = r_frame_err;

   // Two-flop synchronizer for the asynchronous rx line, idling high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_sync    (r_rx_sync),
      .data       (w_data),
      .byte_valid (w_byte_valid),
      .byte_err   (w_byte_err)
   );

   // Inter-byte gap timer: reloaded by every good byte, runs down only while inside a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (w_byte_valid) begin
         r_to_cnt <= TO_LOAD;
      end else if ((r_state != P_HUNT) && (r_to_cnt != '0)) begin
         r_to_cnt <= r_to_cnt - 1'b1;
      end
   end

   // Terminal count; takes priority over a byte completing in the same cycle.
   assign w_timeout = (r_state != P_HUNT) && (r_to_cnt == TO_W'(1));

   // Frame parser with registered write strobe, index, data and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= P_HUNT;
         r_cnt        <= '0;
         r_sum        <= '0;
         r_read_data  <= '0;
         r_idx        <= '0;
         r_update_reg <= 1'b0;
         r_pc_ready   <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_update_reg <= 1'b0;
         r_pc_ready   <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= P_HUNT;
         end else begin
            case (r_state)
               P_HUNT: begin
                  if (w_byte_valid && (w_data == SYNC_BYTE)) begin
                     r_cnt   <= '0;
                     r_sum   <= '0;
                     r_state <= P_PAYLOAD;
                  end
               end
               P_PAYLOAD: begin
                  if (w_byte_err) begin
                     r_frame_err <= 1'b1;
                     r_state     <= P_HUNT;
                  end else if (w_byte_valid) begin
                     r_read_data  <= w_data;
                     r_idx        <= r_cnt;
                     r_update_reg <= 1'b1;
                     r_sum        <= r_sum + w_data;
                     if (r_cnt == LAST_IDX) begin
                        r_state <= P_CHECK;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               P_CHECK: begin
                  if (w_byte_err) begin
                     r_frame_err <= 1'b1;
                     r_state     <= P_HUNT;
                  end else if (w_byte_valid) begin
                     if (w_data == r_sum) begin
                        r_pc_ready <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                     r_state <= P_HUNT;
                  end
               end
               default: r_state <= P_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized bench for uart_frame_loader against a byte-level frame model.
module tb_uart_frame_loader;

   localparam int CPB = 8;
   localparam int NB  = 60;
   localparam int TO  = 16 * CPB;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] read_data;
   logic [5:0] idx;
   logic       update_reg;
   logic       pc_ready;
   logic       frame_err;

   always #5 clk = ~clk;

   uart_frame_loader #(
      .CLKS_PER_BIT (CPB),
      .FRAME_BYTES  (NB),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .read_data  (read_data),
      .idx        (idx),
      .update_reg (update_reg),
      .pc_ready   (pc_ready),
      .frame_err  (frame_err)
   );

   // kind: 0 = write, 1 = pc_ready, 2 = frame_err
   typedef struct {
      int kind;
      int ix;
      int dat;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   bit  m_in_frame = 1'b0;
   int  m_cnt      = 0;
   int  m_sum      = 0;

   logic [7:0] pl [NB];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Frame model: works on whole received bytes, not on bit timing.
   function automatic void push_exp(input int k, input int i, input int d);
      ev_t e;
      e.kind = k;
      e.ix   = i;
      e.dat  = d;
      exp_q.push_back(e);
   endfunction

   function automatic void model_byte(input int d, input bit ok);
      if (!ok) begin
         if (m_in_frame) begin
            push_exp(2, 0, 0);
            m_in_frame = 1'b0;
         end
      end else if (!m_in_frame) begin
         if (d == 'hA5) begin
            m_in_frame = 1'b1;
            m_cnt      = 0;
            m_sum      = 0;
         end
      end else if (m_cnt < NB) begin
         push_exp(0, m_cnt, d);
         m_sum = (m_sum + d) % 256;
         m_cnt++;
      end else begin
         push_exp((d == m_sum) ? 1 : 2, 0, 0);
         m_in_frame = 1'b0;
      end
   endfunction

   function automatic void model_timeout();
      if (m_in_frame) begin
         push_exp(2, 0, 0);
         m_in_frame = 1'b0;
      end
   endfunction

   function automatic logic [7:0] csum();
      int s = 0;
      for (int i = 0; i < NB; i++) s += int'(pl[i]);
      return 8'(s % 256);
   endfunction

   function automatic int n_obs(input int k);
      int n = 0;
      foreach (obs_q[i]) if (obs_q[i].kind == k) n++;
      return n;
   endfunction

   function automatic int pack_ev(input ev_t e);
      return (e.kind << 16) | (e.ix << 8) | e.dat;
   endfunction

   // Record every strobe; at most one may be high in any cycle.
   always @(negedge clk) begin
      if (rst_n && (update_reg || pc_ready || frame_err)) begin
         ev_t e;
         check("strobe_excl", int'(update_reg) + int'(pc_ready) + int'(frame_err), 1);
         e.kind = update_reg ? 0 : (pc_ready ? 1 : 2);
         e.ix   = update_reg ? int'(idx) : 0;
         e.dat  = update_reg ? int'(read_data) : 0;
         obs_q.push_back(e);
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap);
      model_byte(int'(d), stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         rx = d[b];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic idle_long();
      rx = 1'b1;
      repeat (TO + 100) @(negedge clk);
      model_timeout();
   endtask

   task automatic send_frame(input logic [7:0] ck);
      send_byte(8'hA5, 1'b1, 2);
      for (int i = 0; i < NB; i++) send_byte(pl[i], 1'b1, 2);
      send_byte(ck, 1'b1, 2);
   endtask

   // Random byte: occasional long pre-gap and occasional stop-bit error.
   task automatic send_rnd(input logic [7:0] d);
      if ($urandom_range(0, 49) == 0) idle_long();
      send_byte(d, ($urandom_range(0, 63) != 0), $urandom_range(2, 10));
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_ev%0d", tag, i), pack_ev(obs_q[i]), pack_ev(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_read_data"}, int'(read_data), 0);
      check({tag, "_idx"}, int'(idx), 0);
      check({tag, "_update_reg"}, int'(update_reg), 0);
      check({tag, "_pc_ready"}, int'(pc_ready), 0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog expired, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ck;
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 1: counting payload, good checksum
      for (int i = 0; i < NB; i++) pl[i] = 8'(i);
      send_frame(8'hEA);
      idle_long();
      check("s1_writes", n_obs(0), 60);
      check("s1_pc_ready", n_obs(1), 1);
      check("s1_frame_err", n_obs(2), 0);
      compare("s1");

      // 2: same payload, wrong checksum
      send_frame(8'hEB);
      idle_long();
      check("s2_writes", n_obs(0), 60);
      check("s2_pc_ready", n_obs(1), 0);
      check("s2_frame_err", n_obs(2), 1);
      compare("s2");

      // 3: junk before sync
      send_byte(8'h00, 1'b1, 3);
      send_byte(8'h3C, 1'b1, 3);
      send_byte(8'hFF, 1'b1, 3);
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
      send_frame(csum());
      idle_long();
      check("s3_writes", n_obs(0), 60);
      check("s3_pc_ready", n_obs(1), 1);
      compare("s3");

      // 4: sync value inside payload is data
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
      pl[10] = 8'hA5;
      send_frame(csum());
      idle_long();
      check("s4_pc_ready", n_obs(1), 1);
      compare("s4");

      // 5: truncated frame times out, then a full frame recovers
      send_byte(8'hA5, 1'b1, 2);
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1, 2);
      idle_long();
      check("s5_writes", n_obs(0), 20);
      check("s5_frame_err", n_obs(2), 1);
      compare("s5a");
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
      send_frame(csum());
      idle_long();
      check("s5_pc_ready", n_obs(1), 1);
      compare("s5b");

      // 6: glitch, stop-bit error, reset mid-frame
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      send_byte(8'hA5, 1'b1, 2);
      for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1, 2);
      send_byte(8'h05, 1'b0, CPB);
      idle_long();
      check("s6_writes", n_obs(0), 5);
      check("s6_frame_err", n_obs(2), 1);
      compare("s6a");
      send_byte(8'hA5, 1'b1, 2);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 2);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      m_in_frame = 1'b0;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      compare("s6b");

      // Random streams: noise, a frame with random payload and checksum
      for (int r = 0; r < 3; r++) begin
         int nn;
         nn = $urandom_range(0, 3);
         for (int k = 0; k < nn; k++) send_rnd(8'($urandom));
         for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
         ck = csum();
         if ($urandom_range(0, 1) == 0) ck = ck + 8'($urandom_range(1, 255));
         send_rnd(8'hA5);
         for (int i = 0; i < NB; i++) send_rnd(pl[i]);
         send_rnd(ck);
         idle_long();
         compare($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
